// File: rtl/thermo_to_binary.sv
// -----------------------------------------------------------------------------
// thermo_to_binary
//   Registered 7-bit thermometer-to-binary converter.
//
//   The binary output is the population count of the sampled input. For a
//   clean thermometer code, this is the level. If the code has bubbles, the
//   output degrades to the number of set bits. A separate flag marks samples
//   that were not a clean thermometer code. Both outputs come from the same
//   clock edge, with a latency of one cycle.
//
// Ports
//   clk  in   1  clock; all state changes on the rising edge
//   rst  in   1  asynchronous, active-high reset; forces b=0, err=0
//   i    in   7  thermometer code, i[0] is the lowest level
//   b    out  3  registered population count of i
//   err  out  1  registered flag: sampled i was not a valid thermometer code
// -----------------------------------------------------------------------------
module thermo_to_binary (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] i,
  output logic [2:0] b,
  output logic       err
);

  logic [2:0] b_d;
  logic [2:0] b_q;
  logic       err_d;
  logic       err_q;
  logic [5:0] bubble;

  // A bubble exists at position gi when a set bit sits above a clear bit.
  // A thermometer code is valid exactly when there is no bubble anywhere.
  genvar gi;
  generate
    for (gi = 1; gi < 7; gi++) begin : g_bubble
      assign bubble[gi-1] = i[gi] & ~i[gi-1];
    end
  endgenerate

  // The population count is computed for every input, not only valid codes.
  // Because of this, bubbled codes still produce a meaningful level.
  always_comb begin
    b_d = 3'd0;
    for (int k = 0; k < 7; k++) begin
      b_d = b_d + {2'b00, i[k]};
    end
    err_d = |bubble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      err_q <= err_d;
    end
  end

  assign b   = b_q;
  assign err = err_q;

endmodule

// File: tb/tb_thermo_to_binary.sv
// -----------------------------------------------------------------------------
// tb_thermo_to_binary
//   Scoreboard bench for thermo_to_binary. The stimulus process drives i on
//   the falling edge and queues the expected {b, err}. The monitor pops one
//   entry after each rising edge and compares it against the DUT outputs.
//   The bench checks reset behaviour directly in the stimulus process.
// -----------------------------------------------------------------------------
module tb_thermo_to_binary;

  logic       clk;
  logic       rst;
  logic [6:0] i;
  logic [2:0] b;
  logic       err;

  typedef struct {
    logic [6:0] vec;
    logic [2:0] exp_b;
    logic       exp_err;
    bit         exh;
  } sb_entry_t;

  sb_entry_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_err_hi = 0;

  thermo_to_binary dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .b   (b),
    .err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end else begin
      $display("check %s: %b ok", name, act);
    end
  endtask

  task automatic drive(input logic [6:0] v, input logic [2:0] eb, input logic ee);
    @(negedge clk);
    i = v;
    sb.push_back('{vec: v, exp_b: eb, exp_err: ee, exh: 1'b0});
  endtask

  // Monitor: the outputs are valid one cycle after each driven sample.
  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (e.exh && err === 1'b1) n_err_hi++;
        if (b !== e.exp_b || err !== e.exp_err) begin
          n_fail++;
          $display("FAIL txn i=%b: got b=%b err=%b required b=%b err=%b",
                   e.vec, b, err, e.exp_b, e.exp_err);
        end else begin
          $display("txn i=%b b=%b err=%b ok", e.vec, b, err);
        end
      end
    end
  end

  initial begin
    logic [2:0] pc;
    logic       ve;
    int         budget;

    rst = 1'b1;
    i   = 7'b0;
    #1;
    check("reset_state", {b, err}, 4'b0000);
    repeat (2) @(posedge clk);

    // The first edge after release loads from i.
    @(negedge clk);
    rst = 1'b0;
    i   = 7'b0000111;
    sb.push_back('{vec: 7'b0000111, exp_b: 3'd3, exp_err: 1'b0, exh: 1'b0});

    // Ramp through the valid codes.
    drive(7'b0000000, 3'd0, 1'b0);
    drive(7'b0000001, 3'd1, 1'b0);
    drive(7'b0000011, 3'd2, 1'b0);
    drive(7'b0000111, 3'd3, 1'b0);
    drive(7'b0001111, 3'd4, 1'b0);
    drive(7'b0011111, 3'd5, 1'b0);
    drive(7'b0111111, 3'd6, 1'b0);
    drive(7'b1111111, 3'd7, 1'b0);

    // Holding the input steady keeps the outputs steady.
    drive(7'b0011111, 3'd5, 1'b0);
    drive(7'b0011111, 3'd5, 1'b0);
    drive(7'b0011111, 3'd5, 1'b0);

    // Bubbled codes.
    drive(7'b0001011, 3'd3, 1'b1);
    drive(7'b1000000, 3'd1, 1'b1);
    drive(7'b0101010, 3'd3, 1'b1);
    drive(7'b1111110, 3'd6, 1'b1);

    // Asynchronous reset between edges.
    drive(7'b1111111, 3'd7, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", {b, err}, 4'b0000);
    i = 7'b0001011;
    @(posedge clk);
    #1;
    check("reset_override", {b, err}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    i   = 7'b1111111;
    sb.push_back('{vec: 7'b1111111, exp_b: 3'd7, exp_err: 1'b0, exh: 1'b0});

    // Latency: change i just before an edge.
    drive(7'b0000000, 3'd0, 1'b0);
    @(negedge clk);
    #4;
    i = 7'b0011111;
    sb.push_back('{vec: 7'b0011111, exp_b: 3'd5, exp_err: 1'b0, exh: 1'b0});
    check("latency_pre_edge", {b, err}, 4'b0000);

    // Exhaustive sweep against an independent model.
    for (int v = 0; v < 128; v++) begin
      pc = 3'd0;
      for (int k = 0; k < 7; k++) if (v[k]) pc = pc + 3'd1;
      ve = 1'b1;
      for (int n = 0; n < 8; n++) if (v == ((1 << n) - 1)) ve = 1'b0;
      @(negedge clk);
      i = v[6:0];
      sb.push_back('{vec: v[6:0], exp_b: pc, exp_err: ve, exh: 1'b1});
    end

    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    check("exhaustive_err_count", n_err_hi[3:0] ^ 4'(n_err_hi != 120), 4'(120));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
